// File: rtl/usb_pkg.sv
// Shared types and constants for the USB full-speed transmit serializer.
package usb_pkg;

  typedef enum logic [1:0] {
    CRC_NONE = 2'b00,
    CRC_5    = 2'b01,
    CRC_16   = 2'b10,
    CRC_RSVD = 2'b11
  } crc_mode_t;

  localparam logic [4:0]  CRC5_POLY  = 5'h05;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [4:0]  CRC5_INIT  = 5'h1F;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // {dp, dm} line states
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_t;

endpackage

// File: rtl/usb_crc_serial.sv
// Bit-serial CRC register, MSB-side feedback, data fed LSB first.
module usb_crc_serial #(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY  = '0,
  parameter logic [WIDTH-1:0] INIT  = '1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             clear,
  input  logic             en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] crc_out
);

  logic [WIDTH-1:0] crc_q, crc_d;
  logic             fb;

  always_comb begin
    fb    = crc_q[WIDTH-1] ^ bit_in;
    crc_d = crc_q;
    if (clear) begin
      crc_d = INIT;
    end else if (en) begin
      crc_d = {crc_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) crc_q <= INIT;
    else        crc_q <= crc_d;
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/usb_tx_serializer.sv
// USB full-speed transmit path: SYNC/PID/payload/CRC, bit stuffing, NRZI and EOP
// in one bit-serial pipeline. One bus bit per clk; all pin outputs registered.
module usb_tx_serializer
  import usb_pkg::*;
#(
  parameter int MAX_PAYLOAD_BITS = 64,
  parameter int STUFF_RUN        = 6,
  parameter int SYNC_BITS        = 8,
  parameter int EOP_SE0_BITS     = 2,
  parameter int LEN_W            = $clog2(MAX_PAYLOAD_BITS + 1)
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic [7:0]                  pkt_pid,
  input  logic [MAX_PAYLOAD_BITS-1:0] pkt_data,
  input  logic [LEN_W-1:0]            pkt_len,
  input  logic [1:0]                  crc_mode,
  input  logic                        pkt_in_avail,
  output logic                        encoder_ready,
  output logic                        dp_w,
  output logic                        dm_w,
  output logic                        tx_oe,
  output logic                        tx_done
);

  localparam int CNT_MAX = (SYNC_BITS > MAX_PAYLOAD_BITS) ? SYNC_BITS : MAX_PAYLOAD_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX + EOP_SE0_BITS + 1);
  localparam int RUN_W   = $clog2(STUFF_RUN + 1);

  tx_state_t                   state_q, state_d;
  crc_mode_t                   mode_q, mode_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [RUN_W-1:0]            ones_q, ones_d, ones_base;
  logic                        level_q, level_d, level_base;
  logic                        dp_q, dp_d, dm_q, dm_d, oe_q, oe_d;
  logic                        done_q, done_d, ready_q, ready_d;
  logic [7:0]                  pid_q, pid_d;
  logic [MAX_PAYLOAD_BITS-1:0] data_q, data_d;
  logic [LEN_W-1:0]            len_q, len_d;
  logic                        stuff_now, raw_bit, crc_clear, crc_en;
  logic [4:0]                  crc5_out;
  logic [15:0]                 crc16_out, crc5_tx, crc16_tx;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(MAX_PAYLOAD_BITS)) ? LEN_W'(MAX_PAYLOAD_BITS) : len;
  endfunction

  function automatic logic is_raw(input tx_state_t st);
    return st inside {ST_SYNC, ST_PID, ST_DATA, ST_CRC};
  endfunction

  function automatic logic [CNT_W-1:0] last_idx(input tx_state_t st,
                                                input logic [LEN_W-1:0] len,
                                                input crc_mode_t m);
    case (st)
      ST_SYNC:    last_idx = CNT_W'(SYNC_BITS - 1);
      ST_PID:     last_idx = CNT_W'(7);
      ST_DATA:    last_idx = CNT_W'(len - 1'b1);
      ST_CRC:     last_idx = (m == CRC_16) ? CNT_W'(15) : CNT_W'(4);
      ST_EOP_SE0: last_idx = CNT_W'(EOP_SE0_BITS - 1);
      default:    last_idx = '0;
    endcase
  endfunction

  function automatic tx_state_t next_after(input tx_state_t st,
                                           input logic [LEN_W-1:0] len,
                                           input crc_mode_t m);
    next_after = ST_IDLE;
    case (st)
      ST_SYNC: next_after = ST_PID;
      ST_PID: begin
        if (len != '0)          next_after = ST_DATA;
        else if (m != CRC_NONE) next_after = ST_CRC;
        else                    next_after = ST_EOP_SE0;
      end
      ST_DATA: begin
        if (m != CRC_NONE) next_after = ST_CRC;
        else               next_after = ST_EOP_SE0;
      end
      ST_CRC:     next_after = ST_EOP_SE0;
      ST_EOP_SE0: next_after = ST_EOP_J;
      default:    next_after = ST_IDLE;
    endcase
  endfunction

  // CRC is sent complemented, MSB first: index i of *_tx is the i-th bit on the wire.
  always_comb begin
    crc5_tx  = '0;
    crc16_tx = '0;
    for (int i = 0; i < 5; i++)  crc5_tx[i]  = ~crc5_out[4-i];
    for (int i = 0; i < 16; i++) crc16_tx[i] = ~crc16_out[15-i];
  end

  // state_q/cnt_q name the raw bit last placed on the wire; *_d names the next one.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    ones_d    = ones_q;
    level_d   = level_q;
    pid_d     = pid_q;
    data_d    = data_q;
    len_d     = len_q;
    done_d    = 1'b0;
    crc_clear = 1'b0;
    crc_en    = 1'b0;
    raw_bit   = 1'b0;
    stuff_now = is_raw(state_q) && (ones_q == RUN_W'(STUFF_RUN));

    if (state_q == ST_IDLE) begin
      if (pkt_in_avail) begin
        pid_d     = pkt_pid;
        data_d    = pkt_data;
        len_d     = clamp_len(pkt_len);
        mode_d    = (crc_mode == CRC_RSVD) ? CRC_NONE : crc_mode_t'(crc_mode);
        state_d   = ST_SYNC;
        cnt_d     = '0;
        crc_clear = 1'b1;
      end
    end else if (!stuff_now) begin
      if (cnt_q == last_idx(state_q, len_q, mode_q)) begin
        state_d = next_after(state_q, len_q, mode_q);
        cnt_d   = '0;
        done_d  = (state_q == ST_EOP_J);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Each packet restarts NRZI from J with an empty ones run.
    level_base = (state_q == ST_IDLE) ? 1'b1 : level_q;
    ones_base  = (state_q == ST_IDLE) ? '0 : ones_q;

    if (is_raw(state_d)) begin
      if (!stuff_now) begin
        case (state_d)
          ST_SYNC: raw_bit = (cnt_d == CNT_W'(SYNC_BITS - 1));
          ST_PID: begin
            raw_bit = pid_q[0];
            pid_d   = {1'b0, pid_q[7:1]};
          end
          ST_DATA: begin
            raw_bit = data_q[0];
            data_d  = data_q >> 1;
            crc_en  = 1'b1;
          end
          default: raw_bit = (mode_q == CRC_16) ? crc16_tx[cnt_d[3:0]] : crc5_tx[cnt_d[3:0]];
        endcase
      end
      ones_d  = raw_bit ? ones_base + 1'b1 : '0;
      level_d = raw_bit ? level_base : ~level_base;
    end

    {dp_d, dm_d} = LINE_J;
    oe_d         = 1'b0;
    if (is_raw(state_d)) begin
      {dp_d, dm_d} = level_d ? LINE_J : LINE_K;
      oe_d         = 1'b1;
    end else if (state_d == ST_EOP_SE0) begin
      {dp_d, dm_d} = LINE_SE0;
      oe_d         = 1'b1;
    end else if (state_d == ST_EOP_J) begin
      oe_d = 1'b1;
    end
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
      mode_q  <= CRC_NONE;
      cnt_q   <= '0;
      ones_q  <= '0;
      level_q <= 1'b1;
      dp_q    <= 1'b1;
      dm_q    <= 1'b0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      level_q <= level_d;
      dp_q    <= dp_d;
      dm_q    <= dm_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    pid_q  <= pid_d;
    data_q <= data_d;
    len_q  <= len_d;
  end

  usb_crc_serial #(.WIDTH(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
    .clk     (clk),
    .rst_b   (rst_b),
    .clear   (crc_clear),
    .en      (crc_en),
    .bit_in  (data_q[0]),
    .crc_out (crc5_out)
  );

  usb_crc_serial #(.WIDTH(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
    .clk     (clk),
    .rst_b   (rst_b),
    .clear   (crc_clear),
    .en      (crc_en),
    .bit_in  (data_q[0]),
    .crc_out (crc16_out)
  );

  assign dp_w          = dp_q;
  assign dm_w          = dm_q;
  assign tx_oe         = oe_q;
  assign tx_done       = done_q;
  assign encoder_ready = ready_q;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Directed bench for usb_tx_serializer: decodes NRZI off the pins and compares
// the stuffed bit stream and timing against hand-derived packets.
module tb_usb_tx_serializer;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [7:0]  pkt_pid;
  logic [63:0] pkt_data;
  logic [6:0]  pkt_len;
  logic [1:0]  crc_mode;
  logic        pkt_in_avail;
  logic        encoder_ready, dp_w, dm_w, tx_oe, tx_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  usb_tx_serializer dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .pkt_pid       (pkt_pid),
    .pkt_data      (pkt_data),
    .pkt_len       (pkt_len),
    .crc_mode      (crc_mode),
    .pkt_in_avail  (pkt_in_avail),
    .encoder_ready (encoder_ready),
    .dp_w          (dp_w),
    .dm_w          (dm_w),
    .tx_oe         (tx_oe),
    .tx_done       (tx_done)
  );

  // Called on the negedge of cycle 1 after acceptance; returns on the tx_done cycle.
  task automatic capture(output string bits, output int oe_cyc, output int se0,
                         output int done_at, output int rdy_busy);
    logic lvl;
    bits = ""; oe_cyc = 0; se0 = 0; done_at = -1; rdy_busy = 0; lvl = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      if (tx_done) begin
        done_at = c;
        break;
      end
      if (tx_oe) begin
        oe_cyc++;
        if (encoder_ready) rdy_busy++;
        if (!dp_w && !dm_w) se0++;
        else if (se0 == 0) begin
          if (dp_w == lvl) bits = {bits, "1"};
          else             bits = {bits, "0"};
          lvl = dp_w;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic run_pkt(input logic [7:0] pid, input logic [63:0] data, input logic [6:0] len,
                         input logic [1:0] mode, output string bits, output int oe_cyc,
                         output int se0, output int done_at, output int rdy_busy);
    @(negedge clk);
    pkt_pid = pid; pkt_data = data; pkt_len = len; crc_mode = mode; pkt_in_avail = 1'b1;
    @(negedge clk);
    pkt_in_avail = 1'b0;
    capture(bits, oe_cyc, se0, done_at, rdy_busy);
  endtask

  task automatic test_reset;
    rst_b = 1'b0; pkt_in_avail = 1'b0; pkt_pid = '0; pkt_data = '0; pkt_len = '0; crc_mode = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (dp_w !== 1'b1)          begin n_fail++; $display("FAIL reset_dp: got %b want 1", dp_w); end
    n_checks++; if (dm_w !== 1'b0)          begin n_fail++; $display("FAIL reset_dm: got %b want 0", dm_w); end
    n_checks++; if (tx_oe !== 1'b0)         begin n_fail++; $display("FAIL reset_oe: got %b want 0", tx_oe); end
    n_checks++; if (encoder_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", encoder_ready); end
    n_checks++; if (tx_done !== 1'b0)       begin n_fail++; $display("FAIL reset_done: got %b want 0", tx_done); end
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_token;
    string bits, exp; int oe, se0, dn, rb;
    exp = {"00000001", "10110100", "00000000000", "01000"};
    run_pkt(8'h2D, 64'h0, 7'd11, 2'b01, bits, oe, se0, dn, rb);
    n_checks++; if (bits != exp) begin n_fail++; $display("FAIL token_bits: got %s want %s", bits, exp); end
    n_checks++; if (oe !== 35)   begin n_fail++; $display("FAIL token_oe_cycles: got %0d want 35", oe); end
    n_checks++; if (se0 !== 2)   begin n_fail++; $display("FAIL token_se0: got %0d want 2", se0); end
    n_checks++; if (dn !== 36)   begin n_fail++; $display("FAIL token_done_latency: got %0d want 36", dn); end
    n_checks++; if (rb !== 0)    begin n_fail++; $display("FAIL token_ready_busy: got %0d want 0", rb); end
    n_checks++; if (encoder_ready !== 1'b1) begin n_fail++; $display("FAIL token_ready_at_done: got %b want 1", encoder_ready); end
  endtask

  task automatic test_zero_len;
    string bits, exp; int oe, se0, dn, rb;
    exp = {"00000001", "11000011", "0000000000000000"};
    run_pkt(8'hC3, 64'h0, 7'd0, 2'b10, bits, oe, se0, dn, rb);
    n_checks++; if (bits != exp) begin n_fail++; $display("FAIL zlen_bits: got %s want %s", bits, exp); end
    n_checks++; if (oe !== 35)   begin n_fail++; $display("FAIL zlen_oe_cycles: got %0d want 35", oe); end
  endtask

  task automatic test_crc16_data;
    string bits, exp; int oe, se0, dn, rb;
    exp = {"00000001", "11010010", "0", "1000000000000100"};
    run_pkt(8'h4B, 64'h0, 7'd1, 2'b10, bits, oe, se0, dn, rb);
    n_checks++; if (bits != exp) begin n_fail++; $display("FAIL crc16_bits: got %s want %s", bits, exp); end
    n_checks++; if (dn !== 37)   begin n_fail++; $display("FAIL crc16_done_latency: got %0d want 37", dn); end
  endtask

  task automatic test_stuff;
    string bits, exp; int oe, se0, dn, rb;
    exp = {"00000001", "10000111", "111", "0", "11111"};
    run_pkt(8'hE1, 64'hFF, 7'd8, 2'b00, bits, oe, se0, dn, rb);
    n_checks++; if (bits != exp) begin n_fail++; $display("FAIL stuff_bits: got %s want %s", bits, exp); end
    n_checks++; if (oe !== 28)   begin n_fail++; $display("FAIL stuff_oe_cycles: got %0d want 28", oe); end
  endtask

  task automatic test_trailing_stuff;
    string bits, exp; int oe, se0, dn, rb;
    exp = {"00000001", "10100101", "00111111", "0"};
    run_pkt(8'hA5, 64'hFC, 7'd8, 2'b00, bits, oe, se0, dn, rb);
    n_checks++; if (bits != exp) begin n_fail++; $display("FAIL trail_bits: got %s want %s", bits, exp); end
    n_checks++; if (oe !== 28)   begin n_fail++; $display("FAIL trail_oe_cycles: got %0d want 28", oe); end
    n_checks++; if (se0 !== 2)   begin n_fail++; $display("FAIL trail_se0: got %0d want 2", se0); end
  endtask

  task automatic test_len_clamp_rsvd;
    string bits, exp; int oe, se0, dn, rb;
    exp = {"00000001", "11000011"};
    for (int i = 0; i < 64; i++) exp = {exp, "0"};
    run_pkt(8'hC3, 64'h0, 7'd100, 2'b11, bits, oe, se0, dn, rb);
    n_checks++; if (bits != exp) begin n_fail++; $display("FAIL clamp_bits: got %s want %s", bits, exp); end
    n_checks++; if (oe !== 83)   begin n_fail++; $display("FAIL clamp_oe_cycles: got %0d want 83", oe); end
  endtask

  task automatic test_reset_mid;
    string bits, exp; int oe, se0, dn, rb;
    @(negedge clk);
    pkt_pid = 8'h2D; pkt_data = 64'h7FF; pkt_len = 7'd11; crc_mode = 2'b01; pkt_in_avail = 1'b1;
    @(negedge clk);
    pkt_in_avail = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    n_checks++; if (dp_w !== 1'b1)          begin n_fail++; $display("FAIL midrst_dp: got %b want 1", dp_w); end
    n_checks++; if (dm_w !== 1'b0)          begin n_fail++; $display("FAIL midrst_dm: got %b want 0", dm_w); end
    n_checks++; if (tx_oe !== 1'b0)         begin n_fail++; $display("FAIL midrst_oe: got %b want 0", tx_oe); end
    n_checks++; if (encoder_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", encoder_ready); end
    @(negedge clk);
    rst_b = 1'b1;
    exp = {"00000001", "10110100", "00000000000", "01000"};
    run_pkt(8'h2D, 64'h0, 7'd11, 2'b01, bits, oe, se0, dn, rb);
    n_checks++; if (bits != exp) begin n_fail++; $display("FAIL midrst_bits: got %s want %s", bits, exp); end
    n_checks++; if (dn !== 36)   begin n_fail++; $display("FAIL midrst_done_latency: got %0d want 36", dn); end
  endtask

  task automatic test_back_to_back;
    string bits, exp1, exp2; int oe, se0, dn, rb;
    exp1 = {"00000001", "10000111", "111", "0", "11111"};
    exp2 = {"00000001", "11010010", "0", "1000000000000100"};
    @(negedge clk);
    pkt_pid = 8'hE1; pkt_data = 64'hFF; pkt_len = 7'd8; crc_mode = 2'b00; pkt_in_avail = 1'b1;
    @(negedge clk);
    // Second packet presented while the first is in flight; request stays high.
    pkt_pid = 8'h4B; pkt_data = 64'h0; pkt_len = 7'd1; crc_mode = 2'b10;
    capture(bits, oe, se0, dn, rb);
    n_checks++; if (bits != exp1) begin n_fail++; $display("FAIL b2b_first_bits: got %s want %s", bits, exp1); end
    n_checks++; if (oe !== 28)    begin n_fail++; $display("FAIL b2b_first_oe: got %0d want 28", oe); end
    n_checks++; if (rb !== 0)     begin n_fail++; $display("FAIL b2b_ready_busy: got %0d want 0", rb); end
    n_checks++; if (tx_oe !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_oe: got %b want 0", tx_oe); end
    n_checks++; if (encoder_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_gap_ready: got %b want 1", encoder_ready); end
    @(negedge clk);
    pkt_in_avail = 1'b0;
    n_checks++; if (tx_oe !== 1'b1) begin n_fail++; $display("FAIL b2b_second_start_oe: got %b want 1", tx_oe); end
    n_checks++; if (encoder_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_second_ready: got %b want 0", encoder_ready); end
    capture(bits, oe, se0, dn, rb);
    n_checks++; if (bits != exp2) begin n_fail++; $display("FAIL b2b_second_bits: got %s want %s", bits, exp2); end
    n_checks++; if (dn !== 37)    begin n_fail++; $display("FAIL b2b_second_done: got %0d want 37", dn); end
  endtask

  initial begin
    test_reset();
    test_token();
    test_zero_len();
    test_crc16_data();
    test_stuff();
    test_trailing_stuff();
    test_len_clamp_rsvd();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
